// File: rtl/ps2_cmd_decoder.sv
// PS/2 keyboard front end for the snake game: assembles scan codes from the raw
// PS/2 lines and turns make codes into command levels long enough for a 40 Hz sampler.
module ps2_cmd_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000,
   parameter int STRETCH    = 3750000
) (
   input  logic       clk100Mhz,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       start,
   output logic       pause,
   output logic       resume,
   output logic       stop,
   output logic       u,
   output logic       d,
   output logic       l,
   output logic       r,
   output logic       speedUp,
   output logic       speedDown,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [21:0]   STRETCH_LD   = 22'(STRETCH);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} decodeState_t;

   logic [1:0]    clkSync;
   logic [1:0]    dataSync;
   logic [FW-1:0] filtCnt;
   logic          filtLevel;
   logic          filtPrev;
   logic          fallEdge;
   logic [3:0]    bitCnt;
   logic [9:0]    frameBits;
   logic [TW-1:0] idleCnt;
   logic [7:0]    frameData;
   logic          frameGood;
   decodeState_t  state;
   logic [9:0]    fireVec;
   logic [9:0]    cmdOut;
   logic [21:0]   stretchCnt [10];

   // Both PS/2 lines idle high, so the synchronizers come out of reset at 1.
   always_ff @(posedge clk100Mhz) begin
      if (!resetn) begin
         clkSync  <= 2'b11;
         dataSync <= 2'b11;
      end else begin
         clkSync  <= {clkSync[0], ps2_clk};
         dataSync <= {dataSync[0], ps2_data};
      end
   end

   always_ff @(posedge clk100Mhz) begin
      if (!resetn) begin
         filtLevel <= 1'b1;
         filtPrev  <= 1'b1;
         filtCnt   <= '0;
      end else begin
         filtPrev <= filtLevel;
         if (clkSync[1] == filtLevel) begin
            filtCnt <= '0;
         end else if (filtCnt == FILTER_LAST) begin
            filtLevel <= clkSync[1];
            filtCnt   <= '0;
         end else begin
            filtCnt <= filtCnt + FW'(1);
         end
      end
   end

   assign fallEdge  = filtPrev & ~filtLevel;
   assign frameData = frameBits[8:1];
   // Stop bit is the live data sample on the 11th edge; parity is odd over data+parity.
   assign frameGood = ~frameBits[0] & dataSync[1] & (^frameBits[9:1]);

   always_ff @(posedge clk100Mhz) begin
      if (!resetn) begin
         bitCnt     <= '0;
         frameBits  <= '0;
         idleCnt    <= '0;
         scan_code  <= '0;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fallEdge) begin
            idleCnt <= '0;
            if (bitCnt == 4'd10) begin
               bitCnt <= '0;
               if (frameGood) begin
                  code_valid <= 1'b1;
                  scan_code  <= frameData;
               end else begin
                  frame_err <= 1'b1;
               end
            end else begin
               frameBits[bitCnt] <= dataSync[1];
               bitCnt            <= bitCnt + 4'd1;
            end
         end else if (bitCnt != 4'd0) begin
            if (idleCnt == TIMEOUT_LAST) begin
               bitCnt  <= '0;
               idleCnt <= '0;
            end else begin
               idleCnt <= idleCnt + TW'(1);
            end
         end
      end
   end

   function automatic logic [9:0] cmdMap(input logic [7:0] code);
      case (code)
         8'h1B:   cmdMap = 10'h001;
         8'h4D:   cmdMap = 10'h002;
         8'h2D:   cmdMap = 10'h004;
         8'h76:   cmdMap = 10'h008;
         8'h75:   cmdMap = 10'h010;
         8'h72:   cmdMap = 10'h020;
         8'h6B:   cmdMap = 10'h040;
         8'h74:   cmdMap = 10'h080;
         8'h79:   cmdMap = 10'h100;
         8'h7B:   cmdMap = 10'h200;
         default: cmdMap = 10'h000;
      endcase
   endfunction

   // Prefix bytes are never mapped, so only real make codes can fire here.
   always_comb begin
      fireVec = '0;
      if (code_valid && (state == IDLE || state == EXT)) begin
         fireVec = cmdMap(scan_code);
      end
   end

   always_ff @(posedge clk100Mhz) begin
      if (!resetn) begin
         state <= IDLE;
      end else if (code_valid) begin
         case (state)
            IDLE: begin
               if (scan_code == 8'hE0)      state <= EXT;
               else if (scan_code == 8'hF0) state <= BRK;
               else                         state <= IDLE;
            end
            EXT: begin
               if (scan_code == 8'hF0) state <= EXT_BRK;
               else                    state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A fresh fire reloads the counter, so typematic repeats keep the level high.
   always_ff @(posedge clk100Mhz) begin
      if (!resetn) begin
         for (int i = 0; i < 10; i++) stretchCnt[i] <= '0;
         cmdOut <= '0;
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (fireVec[i]) begin
               stretchCnt[i] <= STRETCH_LD;
               cmdOut[i]     <= 1'b1;
            end else if (stretchCnt[i] != 22'd0) begin
               stretchCnt[i] <= stretchCnt[i] - 22'd1;
               cmdOut[i]     <= (stretchCnt[i] != 22'd1);
            end else begin
               cmdOut[i] <= 1'b0;
            end
         end
      end
   end

   assign start     = cmdOut[0];
   assign pause     = cmdOut[1];
   assign resume    = cmdOut[2];
   assign stop      = cmdOut[3];
   assign u         = cmdOut[4];
   assign d         = cmdOut[5];
   assign l         = cmdOut[6];
   assign r         = cmdOut[7];
   assign speedUp   = cmdOut[8];
   assign speedDown = cmdOut[9];

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Bench for ps2_cmd_decoder: drives PS/2 frames and compares against a
// prefix/window model of the command levels.
module tb_ps2_cmd_decoder;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 500;
   localparam int STRETCH    = 400;
   localparam int HALF       = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       start, pause, resume, stop, u, d, l, r, speedUp, speedDown;
   logic [7:0] scan_code;
   logic       code_valid, frame_err;
   logic [9:0] cmdVec;

   ps2_cmd_decoder #(
      .FILTER_LEN(FILTER_LEN),
      .TIMEOUT(TIMEOUT),
      .STRETCH(STRETCH)
   ) dut (
      .clk100Mhz(clk),
      .resetn(resetn),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .start(start),
      .pause(pause),
      .resume(resume),
      .stop(stop),
      .u(u),
      .d(d),
      .l(l),
      .r(r),
      .speedUp(speedUp),
      .speedDown(speedDown),
      .scan_code(scan_code),
      .code_valid(code_valid),
      .frame_err(frame_err)
   );

   assign cmdVec = {speedDown, speedUp, r, l, d, u, stop, resume, pause, start};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation only: event counts and timestamps taken on the falling edge.
   int         cvCount = 0;
   int         errCount = 0;
   int         cvCycle = 0;
   int         suHigh = 0;
   int         suRise = 0;
   int         riseCyc [10];
   logic [9:0] prevVec = '0;
   always @(negedge clk) begin
      prevVec <= cmdVec;
      if (code_valid) begin
         cvCount <= cvCount + 1;
         cvCycle <= cyc;
      end
      if (frame_err) errCount <= errCount + 1;
      if (speedUp) suHigh <= suHigh + 1;
      if (speedUp && !prevVec[8]) suRise <= suRise + 1;
      for (int i = 0; i < 10; i++) if (cmdVec[i] && !prevVec[i]) riseCyc[i] <= cyc;
   end

   int checkCnt = 0;
   int passCnt = 0;

   int         lastFire [10];
   int         prevFire [10];
   logic       extP, brkP;
   logic [7:0] expScan;

   task automatic modelReset;
      for (int i = 0; i < 10; i++) begin
         lastFire[i] = -100000;
         prevFire[i] = -100000;
      end
      extP = 1'b0;
      brkP = 1'b0;
      expScan = 8'h00;
   endtask

   function automatic int cmdIndex(input logic [7:0] b);
      case (b)
         8'h1B:   return 0;
         8'h4D:   return 1;
         8'h2D:   return 2;
         8'h76:   return 3;
         8'h75:   return 4;
         8'h72:   return 5;
         8'h6B:   return 6;
         8'h74:   return 7;
         8'h79:   return 8;
         8'h7B:   return 9;
         default: return -1;
      endcase
   endfunction

   task automatic modelDecode(input logic [7:0] b, output int k);
      k = -1;
      if (brkP) begin
         brkP = 1'b0;
         extP = 1'b0;
      end else if (b == 8'hF0) begin
         brkP = 1'b1;
      end else if (b == 8'hE0 && !extP) begin
         extP = 1'b1;
      end else begin
         k = cmdIndex(b);
         extP = 1'b0;
      end
   endtask

   function automatic logic [9:0] expVec(input int c);
      logic [9:0] v;
      v = '0;
      for (int i = 0; i < 10; i++) begin
         if ((c > lastFire[i] && c <= lastFire[i] + STRETCH) ||
             (c > prevFire[i] && c <= prevFire[i] + STRETCH)) v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic waitCyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic sendBits(input logic [10:0] fr, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic doFrame(input logic [7:0] b, input logic badPar, input int gap);
      int cv0, er0, k;
      logic [10:0] fr;
      cv0 = cvCount;
      er0 = errCount;
      fr = {1'b1, (~^b) ^ badPar, b, 1'b0};
      sendBits(fr, 11);
      repeat (gap) @(negedge clk);
      for (int w = 0; w < 60 && cvCount == cv0 && errCount == er0; w++) @(negedge clk);
      checkCnt++;
      if (cvCount == cv0 && errCount == er0)
         $display("[TB] FAIL frame_response: no code_valid/frame_err for byte %h", b);
      else passCnt++;
      if (!badPar) begin
         expScan = b;
         modelDecode(b, k);
         if (k >= 0) begin
            prevFire[k] = lastFire[k];
            lastFire[k] = (cvCount != cv0) ? cvCycle : cyc;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checkCnt++;
      if (cmdVec !== 10'h000) $display("[TB] FAIL reset_cmds: got %h want 000", cmdVec);
      else passCnt++;
      checkCnt++;
      if (scan_code !== 8'h00) $display("[TB] FAIL reset_scan: got %h want 00", scan_code);
      else passCnt++;
      checkCnt++;
      if ({code_valid, frame_err} !== 2'b00) $display("[TB] FAIL reset_pulses: got %b want 00", {code_valid, frame_err});
      else passCnt++;
      modelReset();
      resetn = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_make_start;
      int cv0, er0, f;
      cv0 = cvCount;
      er0 = errCount;
      doFrame(8'h1B, 1'b0, 10);
      f = lastFire[0];
      checkCnt++;
      if (scan_code !== expScan) $display("[TB] FAIL start_scan: got %h want %h", scan_code, expScan);
      else passCnt++;
      checkCnt++;
      if (cvCount - cv0 !== 1 || errCount - er0 !== 0)
         $display("[TB] FAIL start_counts: got cv=%0d err=%0d want cv=1 err=0", cvCount - cv0, errCount - er0);
      else passCnt++;
      checkCnt++;
      if (riseCyc[0] !== f + 1) $display("[TB] FAIL start_rise: got cycle %0d want %0d", riseCyc[0], f + 1);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL start_level: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
      waitCyc(f + STRETCH);
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL start_last_cycle: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
      waitCyc(f + STRETCH + 1);
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL start_expired: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
   endtask

   task automatic test_extended;
      int cv0;
      cv0 = cvCount;
      doFrame(8'hE0, 1'b0, 10);
      doFrame(8'h75, 1'b0, 10);
      checkCnt++;
      if (riseCyc[4] !== lastFire[4] + 1) $display("[TB] FAIL ext_u_rise: got cycle %0d want %0d", riseCyc[4], lastFire[4] + 1);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL ext_u_level: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
      doFrame(8'hE0, 1'b0, 10);
      doFrame(8'hF0, 1'b0, 10);
      doFrame(8'h75, 1'b0, 10);
      checkCnt++;
      if (scan_code !== expScan || cvCount - cv0 !== 5)
         $display("[TB] FAIL ext_break: got scan=%h cv=%0d want scan=%h cv=5", scan_code, cvCount - cv0, expScan);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL ext_break_level: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
      doFrame(8'h74, 1'b0, 10);
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL ext_idle_r: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
   endtask

   task automatic test_break;
      int cv0;
      cv0 = cvCount;
      doFrame(8'hF0, 1'b0, 10);
      doFrame(8'h1B, 1'b0, 10);
      checkCnt++;
      if (cvCount - cv0 !== 2) $display("[TB] FAIL brk_pulses: got %0d want 2", cvCount - cv0);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL brk_level: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
      doFrame(8'h6B, 1'b0, 10);
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL brk_idle_l: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
   endtask

   task automatic test_parity;
      int cv0, er0;
      cv0 = cvCount;
      er0 = errCount;
      doFrame(8'h4D, 1'b1, 10);
      checkCnt++;
      if (errCount - er0 !== 1 || cvCount - cv0 !== 0)
         $display("[TB] FAIL parity_counts: got err=%0d cv=%0d want err=1 cv=0", errCount - er0, cvCount - cv0);
      else passCnt++;
      checkCnt++;
      if (scan_code !== expScan) $display("[TB] FAIL parity_scan: got %h want %h", scan_code, expScan);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL parity_level: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
      doFrame(8'h2D, 1'b0, 10);
      checkCnt++;
      if (cmdVec !== expVec(cyc) || scan_code !== expScan)
         $display("[TB] FAIL parity_recover: got %h/%h want %h/%h", cmdVec, scan_code, expVec(cyc), expScan);
      else passCnt++;
   endtask

   task automatic test_timeout;
      int cv0, er0;
      logic [10:0] fr;
      cv0 = cvCount;
      er0 = errCount;
      fr = {1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0};
      sendBits(fr, 5);
      repeat (TIMEOUT + 100) @(negedge clk);
      checkCnt++;
      if (cvCount - cv0 !== 0 || errCount - er0 !== 0)
         $display("[TB] FAIL timeout_silent: got cv=%0d err=%0d want 0/0", cvCount - cv0, errCount - er0);
      else passCnt++;
      doFrame(8'h76, 1'b0, 10);
      checkCnt++;
      if (errCount - er0 !== 0 || cvCount - cv0 !== 1 || scan_code !== expScan)
         $display("[TB] FAIL timeout_next: got err=%0d cv=%0d scan=%h want 0/1/%h", errCount - er0, cvCount - cv0, scan_code, expScan);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL timeout_stop: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
   endtask

   task automatic test_back_to_back;
      int h0, r0, f1, f2, gapC, expHigh, expRise;
      h0 = suHigh;
      r0 = suRise;
      doFrame(8'h79, 1'b0, 10);
      f1 = lastFire[8];
      doFrame(8'h79, 1'b0, 10);
      f2 = lastFire[8];
      gapC = f2 - f1;
      expHigh = (gapC >= STRETCH) ? 2 * STRETCH : gapC + STRETCH;
      expRise = (gapC <= STRETCH) ? 1 : 2;
      waitCyc(f2 + STRETCH + 5);
      checkCnt++;
      if (suRise - r0 !== expRise) $display("[TB] FAIL b2b_rises: got %0d want %0d", suRise - r0, expRise);
      else passCnt++;
      checkCnt++;
      if (suHigh - h0 !== expHigh) $display("[TB] FAIL b2b_high_cycles: got %0d want %0d", suHigh - h0, expHigh);
      else passCnt++;
   endtask

   task automatic test_glitch;
      int cv0, er0;
      cv0 = cvCount;
      er0 = errCount;
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
      doFrame(8'h72, 1'b0, 10);
      checkCnt++;
      if (cvCount - cv0 !== 1 || errCount - er0 !== 0 || scan_code !== expScan)
         $display("[TB] FAIL glitch_frame: got cv=%0d err=%0d scan=%h want 1/0/%h", cvCount - cv0, errCount - er0, scan_code, expScan);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL glitch_level: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
   endtask

   task automatic test_reset_mid;
      int cv0;
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      doFrame(8'h1B, 1'b0, 10);
      repeat (30) @(negedge clk);
      sendBits({1'b1, ~^b, b, 1'b0}, 5);
      resetn = 1'b0;
      @(negedge clk);
      checkCnt++;
      if (cmdVec !== 10'h000 || scan_code !== 8'h00 || {code_valid, frame_err} !== 2'b00)
         $display("[TB] FAIL midreset_outputs: got %h/%h/%b want 000/00/00", cmdVec, scan_code, {code_valid, frame_err});
      else passCnt++;
      modelReset();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (30) @(negedge clk);
      cv0 = cvCount;
      doFrame(8'h74, 1'b0, 10);
      checkCnt++;
      if (cvCount - cv0 !== 1 || scan_code !== expScan)
         $display("[TB] FAIL midreset_next: got cv=%0d scan=%h want 1/%h", cvCount - cv0, scan_code, expScan);
      else passCnt++;
      checkCnt++;
      if (cmdVec !== expVec(cyc)) $display("[TB] FAIL midreset_level: got %h want %h", cmdVec, expVec(cyc));
      else passCnt++;
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      test_reset();
      test_make_start();
      test_extended();
      test_break();
      test_parity();
      test_timeout();
      test_back_to_back();
      test_glitch();
      test_reset_mid();
      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
